// File: rtl/mole_round_ctrl_pkg.sv
// Shared whack-a-mole definitions: hole count, clock frequency and round FSM encoding.
// Also used by the unique-number selector so both sides agree on hole indexing.
package mole_round_ctrl_pkg;

  localparam int CLK_FREQ_HZ = 50_000_000;
  localparam int NUM_HOLES   = 8;
  localparam int HOLE_W      = $clog2(NUM_HOLES);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    REQ       = 3'd1,
    WAIT_SEL  = 3'd2,
    ARMED     = 3'd3,
    RESULT    = 3'd4,
    GAME_OVER = 3'd5
  } state_t;

  function automatic logic [NUM_HOLES-1:0] hole_mask(input logic [HOLE_W-1:0] h);
    hole_mask    = '0;
    hole_mask[h] = 1'b1;
  endfunction

endpackage

// File: rtl/mole_round_ctrl_btn_edge_detect.sv
// Rising-edge detector for the hole buttons; history register updates every cycle,
// so a button already held when a mole lights never reports an edge.
module btn_edge_detect
  import mole_round_ctrl_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [NUM_HOLES-1:0] i_btn,
  output logic [NUM_HOLES-1:0] o_rise
);

  logic [NUM_HOLES-1:0] r_btn_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_btn_q <= '0;
    end else begin
      r_btn_q <= i_btn;
    end
  end

  assign o_rise = i_btn & ~r_btn_q;

endmodule

// File: rtl/mole_round_ctrl.sv
// Whack-a-mole round controller: requests a hole, lights it, judges the first button
// edge or the timeout, pulses hit/miss for one cycle and keeps a saturating score.
module mole_round_ctrl
  import mole_round_ctrl_pkg::*;
#(
  parameter int WINDOW_CYCLES = CLK_FREQ_HZ,
  parameter int SCORE_W       = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 req,
  input  logic                 sel_done,
  input  logic [HOLE_W-1:0]    sel_num,
  input  logic                 all_selected,
  input  logic [NUM_HOLES-1:0] btn,
  output logic [NUM_HOLES-1:0] led,
  output logic [HOLE_W-1:0]    hole,
  output logic                 hit,
  output logic                 miss,
  output logic [SCORE_W-1:0]   score,
  output logic                 game_over
);

  localparam int              WIN_W    = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);

  state_t               r_state;
  state_t               w_next;
  logic [WIN_W-1:0]     r_win;
  logic [NUM_HOLES-1:0] r_led;
  logic [HOLE_W-1:0]    r_hole;
  logic [SCORE_W-1:0]   r_score;
  logic                 r_was_hit;
  logic [NUM_HOLES-1:0] w_rise;
  logic                 w_clean_hit;
  logic                 w_outcome;
  logic                 w_clear_score;

  btn_edge_detect u_btn_edge (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_btn  (btn),
    .o_rise (w_rise)
  );

  // A hit needs the lit hole to be the only button that rose this cycle.
  assign w_clean_hit = (w_rise == hole_mask(r_hole));
  assign w_outcome   = (|w_rise) || (r_win == WIN_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next        = r_state;
    req           = 1'b0;
    hit           = 1'b0;
    miss          = 1'b0;
    game_over     = 1'b0;
    w_clear_score = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_next        = REQ;
          w_clear_score = 1'b1;
        end
      end
      REQ: begin
        if (all_selected) begin
          w_next = GAME_OVER;
        end else begin
          req    = 1'b1;
          w_next = WAIT_SEL;
        end
      end
      WAIT_SEL: begin
        if (sel_done) w_next = ARMED;
      end
      ARMED: begin
        if (w_outcome) w_next = RESULT;
      end
      RESULT: begin
        hit    = r_was_hit;
        miss   = ~r_was_hit;
        w_next = REQ;
      end
      GAME_OVER: begin
        game_over = 1'b1;
        if (start) begin
          w_next        = REQ;
          w_clear_score = 1'b1;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_win     <= '0;
      r_led     <= '0;
      r_hole    <= '0;
      r_score   <= '0;
      r_was_hit <= 1'b0;
    end else begin
      if (w_clear_score) r_score <= '0;
      case (r_state)
        WAIT_SEL: begin
          if (sel_done) begin
            r_hole <= sel_num;
            r_led  <= hole_mask(sel_num);
            r_win  <= '0;
          end
        end
        ARMED: begin
          if (w_outcome) begin
            r_led     <= '0;
            r_was_hit <= w_clean_hit;
            if (w_clean_hit && (r_score != '1)) r_score <= r_score + SCORE_W'(1);
          end else begin
            r_win <= r_win + WIN_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign led   = r_led;
  assign hole  = r_hole;
  assign score = r_score;

endmodule
